// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//   Shared constants and helpers for the multi-channel tick generator.
//   - CLK_HZ / *_DIV : default divisors for a 50 MHz system clock
//                      (1 ms, 10 ms, 100 ms and 1 s periods).
//   - idx_w()        : width of a channel index, never less than 1 bit.
package tick_gen_pkg;

  localparam int CLK_HZ = 50_000_000;
  localparam int MS_DIV = 50_000;
  localparam int CS_DIV = 500_000;
  localparam int DS_DIV = 5_000_000;
  localparam int S_DIV  = 50_000_000;

  // A single channel still needs a 1-bit select port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_multi_chan.sv
// tick_chan
//   One divider channel: divisor register, event counter, wrap detect,
//   registered single-cycle tick and 50 % square output.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     ev        : count event for this cycle (already gated by enables/chain)
//     load      : write load_div into the divisor and restart the count
//     load_div  : new divisor (0 stops the channel)
//     sync      : clear counter, tick and sq
//     wrap      : combinational, high when this event completes a period
//     tick, sq  : registered outputs
module tick_chan #(
  parameter int                 CNT_W   = 26,
  parameter logic [CNT_W-1:0]   DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             sync,
  output logic             wrap,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] div_m1;
  logic             div_nz;
  logic             tick_reg;
  logic             sq_reg;

  assign div_m1 = div_reg - CNT_W'(1);
  assign div_nz = (div_reg != '0);

  // Strict equality with D-1: a zero divisor can never match, and the
  // counter is always cleared when the divisor changes, so it can never
  // run past the limit.
  assign wrap = ev && div_nz && (cnt_reg == div_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      div_reg  <= DIV_RST;
      tick_reg <= 1'b0;
      sq_reg   <= 1'b0;
    end else begin
      // A load or sync in the same cycle as a wrap swallows that tick.
      tick_reg <= wrap && !load && !sync;

      if (load) begin
        div_reg <= load_div;
      end

      if (sync || load || wrap) begin
        cnt_reg <= '0;
      end else if (ev && div_nz) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      if (sync) begin
        sq_reg <= 1'b0;
      end else if (wrap && !load) begin
        sq_reg <= ~sq_reg;
      end
    end
  end

  assign tick = tick_reg;
  assign sq   = sq_reg;

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi
//   Multi-channel clock-enable generator. Each channel divides its count
//   events by a run-time programmable divisor and produces a one-cycle tick
//   and a square wave. A channel may be chained to count the wraps of the
//   channel below it; the upstream wrap is used in the same cycle so
//   aligned ticks of a chain assert together.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     en         : global count enable
//     ch_en      : per-channel count enable
//     chain      : per-channel chain select (registered; bit 0 has no effect)
//     load       : divisor write strobe for channel load_ch
//     load_ch    : target channel (out-of-range indices are ignored)
//     load_div   : new divisor
//     sync       : restart every channel phase-aligned
//     tick, sq   : registered per-channel outputs
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int                      N_CH       = 4,
  parameter int                      CNT_W      = 26,
  parameter logic [N_CH*CNT_W-1:0]   DIV_INIT   = {CNT_W'(S_DIV), CNT_W'(DS_DIV),
                                                   CNT_W'(CS_DIV), CNT_W'(MS_DIV)},
  parameter logic [N_CH-1:0]         CHAIN_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          chain,
  input  logic                     load,
  input  logic [idx_w(N_CH)-1:0]   load_ch,
  input  logic [CNT_W-1:0]         load_div,
  input  logic                     sync,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          sq
);

  localparam int IDX_W = idx_w(N_CH);

  logic [N_CH-1:0] chain_reg;
  logic [N_CH-1:0] wrap;
  logic [N_CH-1:0] wrap_up;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] load_hit;
  logic            wrap_last_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= CHAIN_INIT;
    end else begin
      chain_reg <= chain;
    end
  end

  // Channel 0 has nothing below it: its "upstream wrap" is a constant 1,
  // which makes its chain bit a no-op.
  generate
    if (N_CH > 1) begin : g_up
      assign wrap_up = {wrap[N_CH-2:0], 1'b1};
    end else begin : g_up_single
      assign wrap_up = 1'b1;
    end
  endgenerate

  // The top channel's wrap has no consumer.
  assign wrap_last_unused = wrap[N_CH-1];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ev[gi]       = en && ch_en[gi] && (chain_reg[gi] ? wrap_up[gi] : 1'b1);
      assign load_hit[gi] = load && (load_ch == IDX_W'(gi));

      tick_chan #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .ev       (ev[gi]),
        .load     (load_hit[gi]),
        .load_div (load_div),
        .sync     (sync),
        .wrap     (wrap[gi]),
        .tick     (tick[gi]),
        .sq       (sq[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi
//   Directed scenarios followed by a randomized run. A reference model
//   tracks, per channel, the number of events since the last restart and
//   the number of completed periods; a tick is expected whenever the event
//   count becomes a multiple of the divisor, and sq is the parity of the
//   period count.
module tb_tick_gen_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH-1:0]   chain;
  logic              load;
  logic [1:0]        load_ch;
  logic [CNT_W-1:0]  load_div;
  logic              sync;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   sq;

  tick_gen_multi #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .DIV_INIT   ({8'd3, 8'd2, 8'd5, 8'd4}),
    .CHAIN_INIT (4'b0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_en    (ch_en),
    .chain    (chain),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .sync     (sync),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;

  // Reference model state
  int              div_m   [N_CH];
  int              nev_m   [N_CH];   // events since last restart
  int              nwrap_m [N_CH];   // completed periods since last clear
  logic [N_CH-1:0] chain_m;
  logic [N_CH-1:0] exp_tick;
  logic [N_CH-1:0] exp_sq;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    div_m   = '{4, 5, 2, 3};
    nev_m   = '{0, 0, 0, 0};
    nwrap_m = '{0, 0, 0, 0};
    chain_m = 4'b0000;
    exp_tick = '0;
  endfunction

  // Evaluate the current inputs against the model and advance it by one edge.
  function automatic void model_edge();
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] wr;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        ev[k] = en && ch_en[k] && ((k > 0 && chain_m[k]) ? wr[k-1] : 1'b1);
        wr[k] = ev[k] && (div_m[k] != 0) && (((nev_m[k] + 1) % div_m[k]) == 0);
      end
      for (int k = 0; k < N_CH; k++) begin
        logic hit;
        hit = load && (int'(load_ch) == k);
        exp_tick[k] = wr[k] && !hit && !sync;
        if (hit) div_m[k] = int'(load_div);
        if (sync) begin
          nev_m[k]   = 0;
          nwrap_m[k] = 0;
        end else if (hit) begin
          nev_m[k] = 0;
        end else if (ev[k] && div_m[k] != 0) begin
          nev_m[k]++;
          if (wr[k]) nwrap_m[k]++;
        end
      end
      chain_m = chain;
    end
    for (int k = 0; k < N_CH; k++) exp_sq[k] = nwrap_m[k][0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model, edge, then compare both output vectors.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("sq", 32'(sq), 32'(exp_sq));
  endtask

  // Step until tick[ch] is seen; c is the number of steps taken.
  task automatic wait_tick(input int ch, input int maxc, output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (!tick[ch] && c < maxc);
    if (!tick[ch]) chk("wait_tick_timeout", 32'(c), 32'(0));
  endtask

  task automatic do_load(input int ch, input int d);
    load = 1'b1; load_ch = 2'(ch); load_div = 8'(d);
    step();
    load = 1'b0;
  endtask

  task automatic run_until_phase(input int ch, input int d, input int ph);
    int c = 0;
    while ((nev_m[ch] % d) != ph && c < 50) begin
      step();
      c++;
    end
    chk("phase_reach", 32'(nev_m[ch] % d), 32'(ph));
  endtask

  initial begin
    int c;
    logic sq_hold;
    rst = 1'b1; en = 1'b0; ch_en = '0; chain = '0; load = 1'b0;
    load_ch = '0; load_div = '0; sync = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    step();
    step();
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_sq", 32'(sq), 32'(0));
    $display("step reset: tick=%b sq=%b", tick, sq);

    // Free running with default divisors
    rst = 1'b0; en = 1'b1; ch_en = 4'b1111;
    wait_tick(0, 20, c);
    chk("first_tick0_latency", 32'(c), 32'(4));
    wait_tick(0, 20, c);
    chk("tick0_period", 32'(c), 32'(4));
    repeat (12) step();
    $display("step free-run: tick0 period %0d", c);

    // Chain ch1 onto ch0: 4 * 3 = 12 cycles
    chain = 4'b0010;
    do_load(0, 4);
    do_load(1, 3);
    wait_tick(1, 40, c);
    wait_tick(1, 40, c);
    chk("chain_period", 32'(c), 32'(12));
    chk("chain_aligned_tick0", 32'(tick[0]), 32'(1));
    $display("step chain: tick1 period %0d", c);

    // Divisor 1 then 0 on channel 0
    load = 1'b1; load_ch = 2'd0; load_div = 8'd1;
    step();
    load = 1'b0;
    chk("load_cycle_tick0", 32'(tick[0]), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div1_tick0", 32'(tick[0]), 32'(1));
    end
    do_load(0, 0);
    sq_hold = sq[0];
    for (int i = 0; i < 6; i++) begin
      step();
      chk("div0_tick0", 32'(tick[0]), 32'(0));
      chk("div0_sq0", 32'(sq[0]), 32'(sq_hold));
    end
    $display("step load: div1/div0 done");

    // en dropped mid-period at count 2
    do_load(0, 4);
    run_until_phase(0, 4, 2);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("en_low_tick", 32'(tick), 32'(0));
    end
    en = 1'b1;
    wait_tick(0, 20, c);
    chk("en_resume_latency", 32'(c), 32'(2));
    $display("step en-pause: resume latency %0d", c);

    // sync coincident with a channel 0 wrap
    chain = 4'b0000;
    step();
    run_until_phase(0, 4, 3);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick", 32'(tick), 32'(0));
    chk("sync_sq", 32'(sq), 32'(0));
    repeat (3) step();
    step();
    chk("sync_aligned", 32'({tick[2], tick[0]}), 32'(2'b11));
    $display("step sync: tick=%b", tick);

    // rst mid-period after loading a larger divisor
    do_load(0, 7);
    run_until_phase(0, 7, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_tick", 32'(tick), 32'(0));
    chk("rst_mid_sq", 32'(sq), 32'(0));
    wait_tick(0, 20, c);
    chk("rst_div_restored", 32'(c), 32'(4));
    $display("step mid-reset: tick0 latency %0d", c);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 7) != 0);
      ch_en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      if ($urandom_range(0, 15) == 0) chain = 4'($urandom);
      load     = ($urandom_range(0, 9) == 0);
      load_ch  = 2'($urandom);
      load_div = 8'($urandom_range(0, 5));
      sync     = ($urandom_range(0, 29) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0; sync = 1'b0;
    $display("step random: 400 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
